// File: rtl/serial_tx_pkg.sv
// Shared types for the serial transmitter: FSM state encoding and counter sizing.
// Optional feature macro used by the design: SERIAL_TX_PARITY_EN.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } tx_state_e;

  // Bit counter must be able to hold DATA_W itself (it steps past the last bit).
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Per-bit divider: counts 0..DIV-1 while enabled and marks the bit end and SCLK phase.
// Built the same way with or without SERIAL_TX_PARITY_EN.
module serial_bit_timer
  import serial_tx_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic i_clear,
  input  logic i_en,
  output logic o_bit_end,
  output logic o_sclk_phase,
  output logic o_sclk_rise
);

  localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2);
  localparam logic [DW-1:0] DIV_PRE  = DW'(DIV / 2 - 1);

  logic [DW-1:0] r_div;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_div <= '0;
    end else if (i_clear) begin
      r_div <= '0;
    end else if (i_en) begin
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    end
  end

  assign o_bit_end    = i_en && (r_div == DIV_LAST);
  assign o_sclk_phase = (r_div >= DIV_HALF);
  // One cycle before the second half starts, so a registered SCLK rises on time.
  assign o_sclk_rise  = i_en && (r_div == DIV_PRE);

endmodule

// File: rtl/serial_tx_shifter.sv
// Single-clock parallel-in/serial-out transmitter with holding register and generated SCLK.
// Define SERIAL_TX_PARITY_EN to append one even-parity bit after the data bits.
module serial_tx_shifter
  import serial_tx_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DIV       = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] DIN,
  input  logic              LOAD,
  input  logic              START_TX,
  output logic              TX_BUSY,
  output logic              TX_DONE,
  output logic              SOUT,
  output logic              SCLK
);

  // Handshake: LOAD writes DIN into the holding register on any cycle. START_TX is a
  // one-cycle request honoured only in IDLE (never queued); TX_BUSY covers the frame
  // and TX_DONE pulses in the first idle cycle after it.

  localparam int CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  tx_state_e         r_state;
  tx_state_e         w_state_next;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_next;
  logic [DATA_W-1:0] w_word;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sout;
  logic              r_sclk;
  logic              r_done;
  logic              w_start;
  logic              w_end_frame;
  logic              w_active;
  logic              w_bit_end;
  logic              w_sclk_phase;
  logic              w_sclk_rise;
`ifdef SERIAL_TX_PARITY_EN
  logic              r_parity;
`endif

  function automatic logic edge_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  serial_bit_timer #(.DIV(DIV)) u_timer (
    .CLK         (CLK),
    .RESET       (RESET),
    .i_clear     (w_start),
    .i_en        (w_active),
    .o_bit_end   (w_bit_end),
    .o_sclk_phase(w_sclk_phase),
    .o_sclk_rise (w_sclk_rise)
  );

  assign w_active     = (r_state != IDLE);
  assign w_start      = (r_state == IDLE) && START_TX;
  assign w_word       = LOAD ? DIN : r_hold;
  assign w_shift_next = (MSB_FIRST != 0) ? {r_shift[DATA_W-2:0], 1'b0}
                                         : {1'b0, r_shift[DATA_W-1:1]};
  assign w_end_frame  = w_active && (w_state_next == IDLE);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:   if (START_TX) w_state_next = SHIFT;
      SHIFT: begin
        if (w_bit_end && (r_cnt == CNT_LAST)) begin
`ifdef SERIAL_TX_PARITY_EN
          w_state_next = PARITY;
`else
          w_state_next = IDLE;
`endif
        end
      end
      PARITY: if (w_bit_end) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_sout  <= 1'b0;
      r_sclk  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_done  <= w_end_frame;
      if (LOAD) r_hold <= DIN;
      if (w_start) begin
        r_shift <= w_word;
        r_cnt   <= '0;
        r_sout  <= edge_bit(w_word);
        r_sclk  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        r_parity <= ^w_word;
`endif
      end else if (w_end_frame) begin
        r_sout <= 1'b0;
        r_sclk <= 1'b0;
      end else if (w_active) begin
        // SCLK rises mid-bit and drops back at the bit boundary.
        r_sclk <= w_sclk_rise || (w_sclk_phase && !w_bit_end);
        if (w_bit_end) begin
          r_cnt   <= r_cnt + 1'b1;
          r_shift <= w_shift_next;
`ifdef SERIAL_TX_PARITY_EN
          r_sout  <= (w_state_next == PARITY) ? r_parity : edge_bit(w_shift_next);
`else
          r_sout  <= edge_bit(w_shift_next);
`endif
        end
      end
    end
  end

  assign TX_BUSY = w_active;
  assign TX_DONE = r_done;
  assign SOUT    = r_sout;
  assign SCLK    = r_sclk;

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Bench for serial_tx_shifter: a 32-bit LSB-first DIV=4 instance and an 8-bit MSB-first DIV=2 instance.
// Expected per-cycle {busy,done,sout,sclk} frames come from a bit-list model of each word.
module tb_serial_tx_shifter;

  logic CLK = 1'b0;
  logic RESET;

  logic [31:0] a_din;
  logic        a_load, a_start;
  logic        a_busy, a_done, a_sout, a_sclk;
  logic [7:0]  b_din;
  logic        b_load, b_start;
  logic        b_busy, b_done, b_sout, b_sclk;

  logic [3:0]  exp_a_q[$];
  logic [3:0]  exp_b_q[$];
  logic [31:0] hold_a;
  logic [7:0]  hold_b;
  int          n_total = 0;
  int          n_bad   = 0;

  serial_tx_shifter #(.DATA_W(32), .DIV(4), .MSB_FIRST(0)) dut_a (
    .CLK(CLK), .RESET(RESET), .DIN(a_din), .LOAD(a_load), .START_TX(a_start),
    .TX_BUSY(a_busy), .TX_DONE(a_done), .SOUT(a_sout), .SCLK(a_sclk)
  );

  serial_tx_shifter #(.DATA_W(8), .DIV(2), .MSB_FIRST(1)) dut_b (
    .CLK(CLK), .RESET(RESET), .DIN(b_din), .LOAD(b_load), .START_TX(b_start),
    .TX_BUSY(b_busy), .TX_DONE(b_done), .SOUT(b_sout), .SCLK(b_sclk)
  );

  // clock
  always #5 CLK = ~CLK;

  // scoreboard
  task automatic compare(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got={busy,done,sout,sclk}=%b exp=%b at %0t", name, got, exp, $time);
    end
  endtask

  // Model: list the frame bits, then each bit lasts div cycles with SCLK low
  // for the first half; one idle cycle with TX_DONE follows.
  task automatic push_frame(input bit sel_b, input logic [31:0] w);
    int   dw = sel_b ? 8 : 32;
    int   dv = sel_b ? 2 : 4;
    logic bits[$];
    logic par;
    logic [3:0] e;
    par = 1'b0;
    for (int i = 0; i < dw; i++) begin
      bits.push_back(sel_b ? w[dw-1-i] : w[i]);
      par = par ^ w[i];
    end
`ifdef SERIAL_TX_PARITY_EN
    bits.push_back(par);
`endif
    foreach (bits[i]) begin
      for (int ph = 0; ph < dv; ph++) begin
        e = {1'b1, 1'b0, bits[i], (ph >= dv / 2) ? 1'b1 : 1'b0};
        if (sel_b) exp_b_q.push_back(e); else exp_a_q.push_back(e);
      end
    end
    if (sel_b) exp_b_q.push_back(4'b0100); else exp_a_q.push_back(4'b0100);
  endtask

  // One cycle: sample both DUTs mid-cycle; an empty queue means all-zero outputs.
  task automatic tick();
    logic [3:0] ea, eb;
    @(negedge CLK);
    ea = (exp_a_q.size() > 0) ? exp_a_q.pop_front() : 4'b0000;
    eb = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : 4'b0000;
    compare("dut_a_outs", {a_busy, a_done, a_sout, a_sclk}, ea);
    compare("dut_b_outs", {b_busy, b_done, b_sout, b_sclk}, eb);
  endtask

  // drivers
  task automatic do_load_a(input logic [31:0] w);
    a_din = w; a_load = 1'b1; hold_a = w;
    tick();
    a_load = 1'b0;
  endtask

  task automatic start_a(input bit with_load, input logic [31:0] w);
    a_start = 1'b1;
    if (with_load) begin a_load = 1'b1; a_din = w; hold_a = w; end
    push_frame(1'b0, hold_a);
    tick();
    a_start = 1'b0; a_load = 1'b0;
  endtask

  task automatic start_b(input bit with_load, input logic [7:0] w);
    b_start = 1'b1;
    if (with_load) begin b_load = 1'b1; b_din = w; hold_b = w; end
    push_frame(1'b1, {24'h0, hold_b});
    tick();
    b_start = 1'b0; b_load = 1'b0;
  endtask

  // Ends in the TX_DONE cycle of the last queued frame.
  task automatic drain();
    int guard = 0;
    while ((exp_a_q.size() > 0 || exp_b_q.size() > 0) && guard < 5000) begin
      tick();
      guard++;
    end
    n_total++;
    if (guard >= 5000) begin
      n_bad++;
      $display("FAIL drain_budget got=%0d exp<5000", guard);
    end
  endtask

  typedef struct {
    logic [31:0] din;
    bit          load_sep;
    bit          load_with_start;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{32'h1234_5678, 1'b1, 1'b0, 32'h1234_5678};
    vecs[1] = '{32'hDEAD_BEEF, 1'b0, 1'b0, 32'h1234_5678};
    vecs[2] = '{32'h0000_00FF, 1'b0, 1'b1, 32'h0000_00FF};
    vecs[3] = '{32'h8000_0001, 1'b1, 1'b0, 32'h8000_0001};

    RESET = 1'b1;
    a_din = '0; a_load = 1'b0; a_start = 1'b0;
    b_din = '0; b_load = 1'b0; b_start = 1'b0;
    hold_a = '0; hold_b = '0;
    tick();
    tick();
    RESET = 1'b0;
    tick();

    // table: each entry names the word that must appear on the line
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].load_sep) do_load_a(vecs[i].din);
      else if (!vecs[i].load_with_start) a_din = vecs[i].din;
      start_a(vecs[i].load_with_start, vecs[i].din);
      n_total++;
      if (hold_a !== vecs[i].exp_word) begin
        n_bad++;
        $display("FAIL vec_word got=%h exp=%h", hold_a, vecs[i].exp_word);
      end
      drain();
      tick();
    end

    // MSB-first 8-bit instance
    start_b(1'b1, 8'hA5);
    drain();
    start_b(1'b1, 8'h07);
    drain();

    // load during a transfer, ignored START_TX mid-frame, back-to-back start
    do_load_a(32'h0000_000F);
    start_a(1'b0, 32'h0);
    repeat (20) tick();
    do_load_a(32'h0000_00F0);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    drain();
    start_a(1'b0, 32'h0);
    drain();

    // reset around bit 5 aborts the frame with no TX_DONE
    start_a(1'b0, 32'h0);
    repeat (5 * 4 + 1) tick();
    RESET = 1'b1;
    exp_a_q.delete();
    exp_b_q.delete();
    hold_a = '0; hold_b = '0;
    tick();
    tick();
    RESET = 1'b0;
    tick();
    start_a(1'b0, 32'h0);
    drain();
    start_a(1'b1, 32'h0000_00FF);
    drain();

    // randomized traffic against the model
    for (int i = 0; i < 16; i++) begin
      logic [31:0] w;
      int mode;
      w = $urandom();
      mode = $urandom_range(0, 2);
      if (mode == 0) do_load_a(w);
      start_a(mode == 1, w);
      repeat ($urandom_range(1, 60)) tick();
      if ($urandom_range(0, 1) == 1) do_load_a($urandom());
      drain();
      repeat ($urandom_range(0, 3)) tick();
    end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w;
      w = 8'($urandom());
      start_b($urandom_range(0, 1) == 1, w);
      drain();
      repeat ($urandom_range(0, 2)) tick();
    end
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_tx_shifter.md
# serial_tx_shifter

Parametrised parallel-in/serial-out transmitter for word-level serial links. It replaces the fixed 32-bit, two-clock shifter with a single-clock design: an internal bit-rate divider, a generated serial clock, selectable bit order and a holding register, so the next word can be loaded while the current one shifts. It sits between the parallel datapath (word source) and the serial pin driver.

## Interface
- DATA_W, 32, word width in bits (≥2)
- DIV, 4, CLK cycles per serial bit (even, ≥2)
- MSB_FIRST, 0, 0 = bit 0 sent first, 1 = bit DATA_W-1 sent first

- CLK  in  1  system clock, all logic on posedge
- RESET  in  1  asynchronous, active-high reset
- DIN  in  DATA_W  parallel word
- LOAD  in  1  write DIN into holding register
- START_TX  in  1  request transmission of holding register
- TX_BUSY  out  1  high while a word is shifting
- TX_DONE  out  1  one-cycle pulse after the last bit period
- SOUT  out  1  serial data, registered
- SCLK  out  1  serial clock, registered; receiver samples on rising edge

## Operation
- Reset: all outputs 0; holding register, shift register, bit counter and divider cleared; state IDLE.
- Holding register: written on any cycle with LOAD=1, in any state, including during TX_BUSY. The word in flight is never affected.
- States:
  - IDLE
  - SHIFT
  - PARITY (only with the macro)
- IDLE → SHIFT on START_TX=1:
  - Shift register ← holding register, or ← DIN directly if LOAD=1 in the same cycle.
  - Bit counter ← 0, divider ← 0.
- START_TX in SHIFT or PARITY is ignored. It is not queued.
- SHIFT:
  - SOUT presents the current bit for exactly DIV cycles.
  - SCLK = 0 for the first DIV/2 cycles of each bit and 1 for the remaining DIV/2.
  - At divider = DIV-1: the register shifts (right if MSB_FIRST=0, left otherwise), the counter increments and the divider wraps.
  - After bit DATA_W-1 → IDLE, or → PARITY when the macro is compiled in.
- Return to IDLE: SOUT ← 0, SCLK ← 0, TX_DONE ← 1 for one cycle.
- Counter width: $clog2(DATA_W+1). The divider counts 0..DIV-1 and wraps to 0.

## Timing
- START_TX sampled at edge k:
  - TX_BUSY = 1 and the first bit is on SOUT from cycle k+1.
  - TX_BUSY stays 1 for exactly N·DIV cycles, where N = DATA_W (+1 with parity).
- TX_DONE = 1 in the cycle immediately after TX_BUSY falls; TX_BUSY = 0 in that cycle.
- A START_TX in the TX_DONE cycle is accepted, giving back-to-back words with no idle bit period.
- First SCLK rising edge occurs at cycle k+1+DIV/2, mid-bit.
- RESET mid-transfer aborts immediately: SOUT, SCLK, TX_BUSY and TX_DONE go to 0 and no TX_DONE pulse is produced.

## Configuration
- SERIAL_TX_PARITY_EN defined:
  - After the data bits, one even-parity bit (XOR of the transmitted word) is sent for DIV cycles in state PARITY, with the same SCLK shape.
  - TX_BUSY lasts (DATA_W+1)·DIV cycles.
- Not defined: no PARITY state; the frame is DATA_W bits only.

## Structure
- Package serial_tx_pkg holds:
  - the state enum (IDLE, SHIFT, PARITY)
  - the function computing counter width from DATA_W
- Sub-module serial_bit_timer holds the DIV divider. It outputs bit_end (divider = DIV-1) and sclk_phase (divider ≥ DIV/2).
- The FSM, holding register and shift register stay in the top module.

## Test plan
- DATA_W=32, DIV=4, LSB first: LOAD 0x12345678, then START_TX.
  - SOUT bit sequence 0,0,0,1,1,1,1,0,…, each bit held 4 cycles.
  - TX_BUSY high for 128 cycles; TX_DONE single pulse at cycle 129.
- DATA_W=8, MSB_FIRST=1, DIV=2: send 0xA5.
  - SOUT 1,0,1,0,0,1,0,1.
  - SCLK rising edge mid-bit on each of the 8 bits.
- LOAD 0xFF with START_TX in the same cycle while the holding register contains 0x00 → 0xFF is transmitted.
- During a transfer of 0x0F, LOAD 0xF0; START_TX in the TX_DONE cycle.
  - The first word completes unchanged.
  - 0xF0 follows with no gap.
- RESET asserted at bit 5 of a transfer.
  - All outputs 0 on the next sample.
  - No TX_DONE pulse.
  - A subsequent START_TX transmits correctly.
- SERIAL_TX_PARITY_EN, DATA_W=8, send 0x07.
  - Ninth bit = 1.
  - TX_BUSY high for 9·DIV cycles.
